// File: rtl/led_display_package.sv
// Shared definitions for the LED display path: PWM duty type and the
// prescaler divide helper used by the PWM generators.
package led_display_package;

    localparam int unsigned PWM_BIT_W = 8;

    typedef logic [PWM_BIT_W-1:0] pwm_duty_t;

    // Integer divide, never below 1 so a fast PWM request still ticks every clock.
    function automatic int unsigned pwm_div(
        input longint unsigned sys_clk,
        input longint unsigned pwm_freq,
        input int unsigned     bit_w
    );
        longint unsigned d;
        d = sys_clk / (pwm_freq * (64'd1 << bit_w));
        if (d < 64'd1) begin
            d = 64'd1;
        end
        return d[31:0];
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator for the PWM period counter: one tick every DIV clocks
// while enabled, counter parked at 0 while disabled.
module pwm_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  logic clk_in,
    input  logic n_reset_in,
    input  logic enable_in,
    output logic tick_out
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        tick_out = 1'b0;
        if (!enable_in) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d    = '0;
            tick_out = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_generator_multi.sv
// Multi-channel PWM generator: shared period counter, double-buffered duty
// registers applied only at period boundaries, optional phase staggering.
module pwm_generator_multi
    import led_display_package::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 100_000_000,
    parameter int unsigned PWM_FREQ     = 20_480,
    parameter int unsigned BIT_W        = 8,
    parameter int unsigned NUM_CH       = 3,
    parameter bit          STAGGER      = 1'b0,
    parameter bit          SIMULATION   = 1'b0
) (
    input  logic                    clk_in,
    input  logic                    n_reset_in,
    input  logic                    enable_in,
    input  logic [NUM_CH*BIT_W-1:0] duty_in,
    input  logic                    duty_valid_in,
    output logic                    duty_ready_out,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start_out
);

    localparam int unsigned DIV    = SIMULATION ? 1 : pwm_div(SYS_CLK_FREQ, PWM_FREQ, BIT_W);
    localparam int unsigned PERIOD = 1 << BIT_W;

    logic                    tick;
    logic                    boundary;
    logic                    accept;
    logic                    apply;

    logic [BIT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH*BIT_W-1:0] pending_q, pending_d;
    logic [NUM_CH*BIT_W-1:0] active_q, active_d;
    logic                    pending_full_q, pending_full_d;
    logic                    duty_ready_q, duty_ready_d;
    logic                    period_start_q, period_start_d;
    logic [NUM_CH-1:0]       pwm_q, pwm_d;

    pwm_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .enable_in  (enable_in),
        .tick_out   (tick)
    );

    // With no period running while disabled, a pending set is applied at once.
    always_comb begin
        boundary       = tick && (cnt_q == '1);
        accept         = duty_valid_in && duty_ready_q;
        apply          = pending_full_q && (boundary || !enable_in);

        cnt_d          = cnt_q;
        if (!enable_in) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        pending_d      = accept ? duty_in : pending_q;
        pending_full_d = accept || (pending_full_q && !apply);
        active_d       = apply ? pending_q : active_q;
        duty_ready_d   = !pending_full_d;
        period_start_d = boundary;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [BIT_W-1:0] OFF = STAGGER ? BIT_W'(i * (PERIOD / NUM_CH)) : '0;
        logic [BIT_W-1:0] cnt_ch;
        assign cnt_ch   = cnt_q + OFF;
        assign pwm_d[i] = enable_in && (cnt_ch < active_q[i*BIT_W +: BIT_W]);
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            cnt_q          <= '0;
            pending_q      <= '0;
            active_q       <= '0;
            pending_full_q <= 1'b0;
            duty_ready_q   <= 1'b1;
            period_start_q <= 1'b0;
            pwm_q          <= '0;
        end else begin
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
            pending_full_q <= pending_full_d;
            duty_ready_q   <= duty_ready_d;
            period_start_q <= period_start_d;
            pwm_q          <= pwm_d;
        end
    end

    assign duty_ready_out   = duty_ready_q;
    assign period_start_out = period_start_q;
    assign pwm_out          = pwm_q;

endmodule

// File: doc/pwm_generator_multi.md
# pwm_generator_multi

Multi-channel successor to `pwm_generator`. It drives `NUM_CH` independent PWM outputs from one shared prescaler and period counter. Each channel has a double-buffered duty register, loaded through a valid/ready handshake and applied only at a period boundary, so duty changes never glitch. An optional mode staggers the channel phases to spread LED supply current. The block sits between the display colour path and the LED driver pins.

## Interface
- `SYS_CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `PWM_FREQ`, 20_480: target PWM tick base in Hz. One full period is `2^BIT_W` ticks.
- `BIT_W`, 8: duty resolution in bits.
- `NUM_CH`, 3: number of channels, 1..16.
- `STAGGER`, 0: when 1, channel i is phase-offset by `i*2^BIT_W/NUM_CH` ticks (integer division).
- `SIMULATION`, 0: when 1, the prescaler divide is forced to 1.
- `clk_in`, in, 1: system clock.
- `n_reset_in`, in, 1: reset, asynchronous, active-low.
- `enable_in`, in, 1: global run enable.
- `duty_in`, in, `NUM_CH*BIT_W`: new duty values. Channel i occupies bits `[i*BIT_W +: BIT_W]`.
- `duty_valid_in`, in, 1: `duty_in` is valid.
- `duty_ready_out`, out, 1: the pending buffer is empty and can accept a new duty set.
- `pwm_out`, out, `NUM_CH`: PWM outputs, registered.
- `period_start_out`, out, 1: one-cycle pulse at each period boundary.

## Operation
- **Prescaler divide.** `DIV = max(1, SYS_CLK_FREQ / (PWM_FREQ * 2^BIT_W))`, using integer division. With the defaults, `DIV` = 19. `SIMULATION`=1 forces `DIV` = 1.
- **Tick generation.** The prescaler counts 0..`DIV`-1 and issues `tick` on the cycle it holds `DIV`-1, then wraps to 0.
- **Period counter.** `cnt` is `BIT_W` bits wide and increments on each `tick`, wrapping from `2^BIT_W-1` to 0.
  - The boundary is the `tick` on which `cnt` wraps to 0.
  - `period_start_out` pulses for the cycle after the boundary.
- **Channel phase.** Each channel uses `cnt_i = (cnt + OFF_i) mod 2^BIT_W`.
  - `OFF_i` = 0 when `STAGGER`=0.
  - `OFF_i` = `i*(2^BIT_W/NUM_CH)` when `STAGGER`=1.
- **Channel output.** The next value of `pwm_out[i]` is `(cnt_i < active_duty_i)`.
  - Duty 0 keeps the output always low.
  - Duty `2^BIT_W-1` gives high for `2^BIT_W-1` of every `2^BIT_W` ticks.
- **Handshake.** On `duty_valid_in & duty_ready_out`, `duty_in` is captured into the pending register and `pending_full` is set.
  - `duty_ready_out` is `!pending_full`, registered. It goes low the cycle after acceptance.
- **Boundary apply.** At a boundary with `pending_full`=1, the pending values are copied to `active_duty` for all channels at once and `pending_full` is cleared. `duty_ready_out` returns high the next cycle.
- **Acceptance on a boundary cycle.** This is possible only when pending was already empty. The captured data waits for the next boundary.
- **Repeated valid.** `duty_valid_in` held while `duty_ready_out`=0 is ignored. The data is neither captured nor dropped silently into active.
- **Disable.** With `enable_in`=0:
  - the prescaler and `cnt` are held at 0;
  - `pwm_out` is 0 from the next cycle;
  - `period_start_out` stays 0.
  - The handshake remains live.
  - A pending set is applied immediately, one cycle after capture, because no period is running.
- **Re-enable.** The rising edge of `enable_in` starts a fresh period at `cnt`=0. No `period_start_out` pulse is generated for this start.

## Timing
- **Reset values.** Asynchronous assertion sets:
  - `pwm_out` = 0;
  - `period_start_out` = 0;
  - `duty_ready_out` = 1;
  - `active_duty` = 0, pending cleared;
  - prescaler = 0, `cnt` = 0.
- **Mid-operation reset.** A reset during a period discards all pending and active duty values. The first period after reset release starts at `cnt`=0.
- **Output latency.** `pwm_out` follows the `cnt`/`active_duty` state with one register stage.
- **Period length.** One period is `DIV*2^BIT_W` clocks exactly. With `SIMULATION`=1 and `BIT_W`=8 this is 256 clocks.
- **Handshake timing.** The worst-case time from acceptance to visible duty is one period plus 2 cycles.

## Structure
- **Shared package.** `led_display_package` gains:
  - function `pwm_div(sys_clk, pwm_freq, bit_w)` returning `DIV`, clamped to at least 1;
  - typedef `pwm_duty_t` (`logic [BIT_W-1:0]`, parametrised through the package localparam default).
- **Sub-module.** `pwm_prescaler`, with ports `clk_in`, `n_reset_in`, `enable_in` and `tick_out`, parametrised by `DIV`.
- **Top-level contents.** The top holds the period counter, handshake, shadow registers and per-channel comparators, built with a generate loop.

## Test plan
Benches use `SIMULATION`=1, `BIT_W`=8, `NUM_CH`=3.

1. **Reset.** Hold `n_reset_in`=0 for 10 cycles → `pwm_out`=0, `duty_ready_out`=1, `period_start_out`=0. `period_start_out` first pulses 256 cycles after release with `enable_in`=1.
2. **Duty corner values.** Load duties {0, 128, 255} → after the next boundary, per 256-cycle period ch0 high for 0 cycles, ch1 for 128, ch2 for 255.
3. **Deferred apply.** Load 64 mid-period at `cnt`=100 → `duty_ready_out` is low until the boundary. `pwm_out` keeps the old duty until `cnt` wraps, and shows the new duty from the next period.
4. **Back-pressure.** Hold `duty_valid_in`=1 with a second value while pending is full → only the first value is applied. The second is accepted after `duty_ready_out` rises and applies one period later.
5. **Stagger.** With `STAGGER`=1 and all duties = 85 → the rising edges of ch0, ch1 and ch2 are offset by 85 cycles each (offsets 0, 85, 170). Every channel's high time is 85 cycles.
6. **Disable and reset interruption.**
   - Drop `enable_in` at `cnt`=50 → `pwm_out`=0 on the next cycle, and a duty loaded while disabled is applied within 2 cycles. On re-enable, the period starts at `cnt`=0.
   - Assert reset mid-period → all state returns to reset values immediately.
